// File: rtl/dmem_arbiter_if.sv
// Bundled requester (p0 = LSU, p1 = trace/debug) and data-memory signals of dmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's side.
`timescale 1ns/1ps
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              p0_valid;
    logic              p0_ready;
    logic [ADDR_W-1:0] p0_addr;
    logic              p0_wen;
    logic [31:0]       p0_wdata;
    logic [1:0]        p0_mask;
    logic              p0_rvalid;
    logic [31:0]       p0_rdata;
    logic              p0_err;

    logic              p1_valid;
    logic              p1_ready;
    logic [ADDR_W-1:0] p1_addr;
    logic              p1_wen;
    logic [31:0]       p1_wdata;
    logic [1:0]        p1_mask;
    logic              p1_rvalid;
    logic [31:0]       p1_rdata;
    logic              p1_err;

    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [31:0]       mem_wdata;
    logic [1:0]        mem_mask;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  p0_valid, p0_addr, p0_wen, p0_wdata, p0_mask,
        output p0_ready, p0_rvalid, p0_rdata, p0_err,
        input  p1_valid, p1_addr, p1_wen, p1_wdata, p1_mask,
        output p1_ready, p1_rvalid, p1_rdata, p1_err,
        output mem_req, mem_addr, mem_wen, mem_wdata, mem_mask,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output p0_valid, p0_addr, p0_wen, p0_wdata, p0_mask,
        input  p0_ready, p0_rvalid, p0_rdata, p0_err,
        output p1_valid, p1_addr, p1_wen, p1_wdata, p1_mask,
        input  p1_ready, p1_rvalid, p1_rdata, p1_err,
        input  mem_req, mem_addr, mem_wen, mem_wdata, mem_mask,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin (or LSU-first with DMEM_ARB_LSU_PRIO_EN defined),
// one outstanding req/gnt/rvalid transaction, watchdog turning a lost response into an error.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int ADDR_W  = 32
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus,
    output logic           busy
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    logic [1:0]        state_reg,      state_next;
    logic              last_grant_reg, last_grant_next;
    logic              owner_reg,      owner_next;
    logic [ADDR_W-1:0] addr_reg,       addr_next;
    logic              wen_reg,        wen_next;
    logic [31:0]       wdata_reg,      wdata_next;
    logic [1:0]        mask_reg,       mask_next;
    logic [31:0]       rdata_reg,      rdata_next;
    logic              err_reg,        err_next;
    logic [CNT_W-1:0]  cnt_reg,        cnt_next;

    logic [1:0]        req_valid;
    logic [1:0]        req_wen;
    logic [ADDR_W-1:0] req_addr  [2];
    logic [31:0]       req_wdata [2];
    logic [1:0]        req_mask  [2];

    logic              sel_port;
    logic              accept;
    logic [1:0]        ready_vec;
    logic [1:0]        rvalid_vec;
    logic [1:0]        err_vec;
    logic [31:0]       rdata_vec [2];

    assign req_valid    = {bus.p1_valid, bus.p0_valid};
    assign req_wen      = {bus.p1_wen,   bus.p0_wen};
    assign req_addr[0]  = bus.p0_addr;
    assign req_addr[1]  = bus.p1_addr;
    assign req_wdata[0] = bus.p0_wdata;
    assign req_wdata[1] = bus.p1_wdata;
    assign req_mask[0]  = bus.p0_mask;
    assign req_mask[1]  = bus.p1_mask;

    // With both ports valid the tie-break is either LSU-first or "whoever did not go last".
    always_comb begin
        sel_port = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef DMEM_ARB_LSU_PRIO_EN
            sel_port = 1'b0;
`else
            sel_port = ~last_grant_reg;
`endif
        end else begin
            sel_port = req_valid[1];
        end
    end

    assign accept = (state_reg == ST_IDLE) && (req_valid != 2'b00);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign ready_vec[gi]  = accept && (sel_port == 1'(gi));
            assign rvalid_vec[gi] = (state_reg == ST_RESP) && (owner_reg == 1'(gi));
            assign rdata_vec[gi]  = rvalid_vec[gi] ? rdata_reg : 32'd0;
            assign err_vec[gi]    = rvalid_vec[gi] & err_reg;
        end
    endgenerate

    assign bus.p0_ready  = ready_vec[0];
    assign bus.p1_ready  = ready_vec[1];
    assign bus.p0_rvalid = rvalid_vec[0];
    assign bus.p1_rvalid = rvalid_vec[1];
    assign bus.p0_rdata  = rdata_vec[0];
    assign bus.p1_rdata  = rdata_vec[1];
    assign bus.p0_err    = err_vec[0];
    assign bus.p1_err    = err_vec[1];

    assign bus.mem_req   = (state_reg == ST_ISSUE);
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wen   = wen_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.mem_mask  = mask_reg;
    assign busy          = (state_reg != ST_IDLE);

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        owner_next      = owner_reg;
        addr_next       = addr_reg;
        wen_next        = wen_reg;
        wdata_next      = wdata_reg;
        mask_next       = mask_reg;
        rdata_next      = rdata_reg;
        err_next        = err_reg;
        cnt_next        = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    owner_next      = sel_port;
                    last_grant_next = sel_port;
                    addr_next       = req_addr[sel_port];
                    wen_next        = req_wen[sel_port];
                    wdata_next      = req_wdata[sel_port];
                    mask_next       = req_mask[sel_port];
                    state_next      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_gnt) begin
                    cnt_next   = '0;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_reg != CNT_SAT) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                // A response arriving on the watchdog's last cycle still wins.
                if (bus.mem_rvalid) begin
                    rdata_next = wen_reg ? 32'd0 : bus.mem_rdata;
                    err_next   = 1'b0;
                    state_next = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
                    rdata_next = 32'd0;
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            addr_reg       <= '0;
            wen_reg        <= 1'b0;
            wdata_reg      <= 32'd0;
            mask_reg       <= 2'd0;
            rdata_reg      <= 32'd0;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            owner_reg      <= owner_next;
            addr_reg       <= addr_next;
            wen_reg        <= wen_next;
            wdata_reg      <= wdata_next;
            mask_reg       <= mask_next;
            rdata_reg      <= rdata_next;
            err_reg        <= err_next;
            cnt_reg        <= cnt_next;
        end
    end
endmodule
